// File: rtl/dispatch_packer.sv
// Dispatch-side FIFO between rename (2 pushes/cycle) and the 4-insert issue queue.
// Branch kills clear live bits in place; killed entries still occupy an insert port with valid=0.
module dispatch_packer #(
  parameter int WIDTH_I   = 35,
  parameter int WIDTH_BRM = 3,
  parameter int DEPTH     = 8
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [WIDTH_I-1:0]      i_inst1,
  input  logic [WIDTH_I-1:0]      i_inst2,
  input  logic [WIDTH_BRM-1:0]    i_brtag1,
  input  logic [WIDTH_BRM-1:0]    i_brtag2,
  input  logic [1:0]              i_valid,
  output logic                    o_ready,
  input  logic                    i_qready,
  output logic [WIDTH_I-1:0]      o_inst1,
  output logic [WIDTH_I-1:0]      o_inst2,
  output logic [WIDTH_I-1:0]      o_inst3,
  output logic [WIDTH_I-1:0]      o_inst4,
  output logic [3:0]              o_valid,
  output logic                    o_en,
  input  logic [2**WIDTH_BRM-1:0] i_brkill,
  input  logic                    i_flush
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH_I-1:0]   mem_word [DEPTH];
  logic [WIDTH_BRM-1:0] mem_tag  [DEPTH];
  logic [DEPTH-1:0]     mem_live;
  logic [DEPTH-1:0]     live_next;
  logic [DEPTH-1:0]     kill_hit;
  logic [AW-1:0]        head;
  logic [AW-1:0]        tail;
  logic [CW-1:0]        count;

  logic [1:0]           push_n;
  logic [2:0]           pop_n;
  logic [WIDTH_I-1:0]   push_word [2];
  logic [WIDTH_BRM-1:0] push_tag  [2];
  logic [AW-1:0]        wr_idx    [2];
  logic [AW-1:0]        rd_idx    [4];
  logic [WIDTH_I-1:0]   word_next [4];
  logic [3:0]           valid_next;

  assign o_ready = (count <= CW'(DEPTH - 2));

  // Select how many lanes are written and which lane lands at the tail slot.
  always_comb begin
    push_word[0] = i_inst1;
    push_tag[0]  = i_brtag1;
    push_word[1] = i_inst2;
    push_tag[1]  = i_brtag2;
    push_n       = 2'd0;
    if (o_ready && !i_flush) begin
      case (i_valid)
        2'b01:   push_n = 2'd1;
        2'b10: begin
          push_n       = 2'd1;
          push_word[0] = i_inst2;
          push_tag[0]  = i_brtag2;
        end
        2'b11:   push_n = 2'd2;
        default: push_n = 2'd0;
      endcase
    end else begin
      push_n = 2'd0;
    end
    wr_idx[0] = tail;
    wr_idx[1] = tail + AW'(1);
  end

  // Pop up to four oldest entries; kill this cycle masks valid but not the slot.
  always_comb begin
    pop_n = 3'd0;
    if (i_qready && !i_flush) begin
      if (count > CW'(4)) begin
        pop_n = 3'd4;
      end else begin
        pop_n = count[2:0];
      end
    end else begin
      pop_n = 3'd0;
    end
    for (int k = 0; k < 4; k++) begin
      rd_idx[k] = head + AW'(k);
      if (3'(k) < pop_n) begin
        word_next[k]  = mem_word[rd_idx[k]];
        valid_next[k] = mem_live[rd_idx[k]] & ~i_brkill[mem_tag[rd_idx[k]]];
      end else begin
        word_next[k]  = '0;
        valid_next[k] = 1'b0;
      end
    end
  end

  // Next live vector: kill stored entries, then mark fresh writes (checked against kill too).
  always_comb begin
    for (int e = 0; e < DEPTH; e++) begin
      kill_hit[e] = i_brkill[mem_tag[e]];
    end
    live_next = mem_live & ~kill_hit;
    if (push_n != 2'd0) begin
      live_next[wr_idx[0]] = ~i_brkill[push_tag[0]];
    end else begin
      live_next = live_next;
    end
    if (push_n == 2'd2) begin
      live_next[wr_idx[1]] = ~i_brkill[push_tag[1]];
    end else begin
      live_next = live_next;
    end
  end

  // Pointer, occupancy and live-bit state.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      mem_live <= '0;
    end else if (i_flush) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      mem_live <= '0;
    end else begin
      head     <= head + AW'(pop_n);
      tail     <= tail + AW'(push_n);
      count    <= count + CW'(push_n) - CW'(pop_n);
      mem_live <= live_next;
    end
  end

  // Payload storage; contents are meaningful only where live/count say so.
  always_ff @(posedge i_clk) begin
    if (push_n != 2'd0) begin
      mem_word[wr_idx[0]] <= push_word[0];
      mem_tag[wr_idx[0]]  <= push_tag[0];
    end
    if (push_n == 2'd2) begin
      mem_word[wr_idx[1]] <= push_word[1];
      mem_tag[wr_idx[1]]  <= push_tag[1];
    end
  end

  // Registered insert-port outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_inst1 <= '0;
      o_inst2 <= '0;
      o_inst3 <= '0;
      o_inst4 <= '0;
      o_valid <= 4'b0000;
      o_en    <= 1'b0;
    end else if (i_flush) begin
      o_inst1 <= '0;
      o_inst2 <= '0;
      o_inst3 <= '0;
      o_inst4 <= '0;
      o_valid <= 4'b0000;
      o_en    <= 1'b0;
    end else begin
      o_inst1 <= word_next[0];
      o_inst2 <= word_next[1];
      o_inst3 <= word_next[2];
      o_inst4 <= word_next[3];
      o_valid <= valid_next;
      o_en    <= |valid_next;
    end
  end

endmodule

// File: tb/tb_dispatch_packer.sv
// Directed bench for dispatch_packer: reset, latency, fill/stall, wrap, kill, flush.
module tb_dispatch_packer;
  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic [34:0] i_inst1 = '0, i_inst2 = '0;
  logic [2:0]  i_brtag1 = '0, i_brtag2 = '0;
  logic [1:0]  i_valid = 2'b00;
  logic        o_ready;
  logic        i_qready = 1'b0;
  logic [34:0] o_inst1, o_inst2, o_inst3, o_inst4;
  logic [3:0]  o_valid;
  logic        o_en;
  logic [7:0]  i_brkill = '0;
  logic        i_flush = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  dispatch_packer #(.WIDTH_I(35), .WIDTH_BRM(3), .DEPTH(8)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_inst1(i_inst1), .i_inst2(i_inst2),
    .i_brtag1(i_brtag1), .i_brtag2(i_brtag2),
    .i_valid(i_valid), .o_ready(o_ready), .i_qready(i_qready),
    .o_inst1(o_inst1), .o_inst2(o_inst2), .o_inst3(o_inst3), .o_inst4(o_inst4),
    .o_valid(o_valid), .o_en(o_en), .i_brkill(i_brkill), .i_flush(i_flush)
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [34:0] w(input int n);
    return {3'b101, 32'(n)};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs, advance past the edge, leave time at edge+1.
  task automatic cyc(input logic [1:0] v, input logic [34:0] a, input logic [2:0] ta,
                     input logic [34:0] b, input logic [2:0] tb, input logic q,
                     input logic [7:0] k, input logic fl);
    i_valid = v; i_inst1 = a; i_brtag1 = ta; i_inst2 = b; i_brtag2 = tb;
    i_qready = q; i_brkill = k; i_flush = fl;
    if (v != 2'b00) chk("proto_ready", o_ready, 1);
    @(posedge i_clk); #1;
  endtask

  task automatic idle(input logic q);
    cyc(2'b00, '0, 3'd0, '0, 3'd0, q, 8'h00, 1'b0);
  endtask

  task automatic push2(input int a, input int b, input logic q);
    cyc(2'b11, w(a), 3'd0, w(b), 3'd0, q, 8'h00, 1'b0);
  endtask

  task automatic outs(input string tag, input logic [3:0] v, input logic [34:0] i1,
                      input logic [34:0] i2, input logic [34:0] i3, input logic [34:0] i4);
    chk({tag, "_valid"}, o_valid, v);
    chk({tag, "_en"}, o_en, |v);
    chk({tag, "_i1"}, o_inst1, i1);
    chk({tag, "_i2"}, o_inst2, i2);
    chk({tag, "_i3"}, o_inst3, i3);
    chk({tag, "_i4"}, o_inst4, i4);
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge i_clk);
    #1;
    chk("rst_valid", o_valid, 4'b0000);
    chk("rst_en", o_en, 0);
    chk("rst_ready", o_ready, 1);
    i_rst = 1'b0;

    // 1: reset mid-burst with count=5
    push2(1, 2, 1'b0);
    push2(3, 4, 1'b0);
    cyc(2'b01, w(5), 3'd0, '0, 3'd0, 1'b0, 8'h00, 1'b0);
    chk("c5_ready", o_ready, 1);
    i_valid = 2'b00; i_qready = 1'b1;
    #2 i_rst = 1'b1;
    #1;
    chk("t1_valid", o_valid, 4'b0000);
    chk("t1_en", o_en, 0);
    chk("t1_ready", o_ready, 1);
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    idle(1'b1);
    idle(1'b1);
    outs("t1_after", 4'b0000, '0, '0, '0, '0);

    // 2: basic latency
    push2(16, 17, 1'b1);
    chk("t2_n1_valid", o_valid, 4'b0000);
    idle(1'b1);
    outs("t2_n2", 4'b0011, w(16), w(17), '0, '0);
    idle(1'b1);
    chk("t2_empty", o_valid, 4'b0000);

    // 3: fill and stall
    push2(32, 33, 1'b0);
    push2(34, 35, 1'b0);
    push2(36, 37, 1'b0);
    chk("t3_c6_ready", o_ready, 1);
    push2(38, 39, 1'b0);
    chk("t3_c8_ready", o_ready, 0);
    chk("t3_stall_valid", o_valid, 4'b0000);
    idle(1'b1);
    outs("t3_pop1", 4'b1111, w(32), w(33), w(34), w(35));
    chk("t3_ready_back", o_ready, 1);
    idle(1'b1);
    outs("t3_pop2", 4'b1111, w(36), w(37), w(38), w(39));
    idle(1'b1);
    chk("t3_drained", o_valid, 4'b0000);

    // 4: wrap -- advance head/tail to 6, then store across 7->0
    push2(48, 49, 1'b0);
    push2(50, 51, 1'b0);
    idle(1'b1);
    outs("t4_pre", 4'b1111, w(48), w(49), w(50), w(51));
    idle(1'b0);
    push2(64, 65, 1'b0);
    push2(66, 67, 1'b0);
    push2(68, 69, 1'b0);
    idle(1'b1);
    outs("t4_wrap1", 4'b1111, w(64), w(65), w(66), w(67));
    idle(1'b1);
    outs("t4_wrap2", 4'b0011, w(68), w(69), '0, '0);
    idle(1'b1);
    chk("t4_empty", o_valid, 4'b0000);

    // 5: kill tag 1 in the pop cycle, plus a same-cycle tag-1 push
    cyc(2'b11, w(80), 3'd0, w(81), 3'd1, 1'b0, 8'h00, 1'b0);
    cyc(2'b11, w(82), 3'd1, w(83), 3'd2, 1'b0, 8'h00, 1'b0);
    cyc(2'b11, w(84), 3'd1, w(85), 3'd0, 1'b1, 8'b0000_0010, 1'b0);
    outs("t5_kill", 4'b1001, w(80), w(81), w(82), w(83));
    idle(1'b1);
    outs("t5_deadpush", 4'b0010, w(84), w(85), '0, '0);
    cyc(2'b11, w(86), 3'd3, w(87), 3'd5, 1'b0, 8'h00, 1'b0);
    cyc(2'b00, '0, 3'd0, '0, 3'd0, 1'b0, 8'b0000_1000, 1'b0);
    idle(1'b1);
    outs("t5_stored_kill", 4'b0010, w(86), w(87), '0, '0);
    cyc(2'b01, w(88), 3'd6, '0, 3'd0, 1'b0, 8'h00, 1'b0);
    cyc(2'b00, '0, 3'd0, '0, 3'd0, 1'b1, 8'b0100_0000, 1'b0);
    outs("t5_allkill", 4'b0000, w(88), '0, '0, '0);
    idle(1'b1);
    chk("t5_empty", o_valid, 4'b0000);

    // count=7 boundary, then 6: flush with concurrent push and pop
    push2(120, 121, 1'b0);
    push2(122, 123, 1'b0);
    push2(124, 125, 1'b0);
    cyc(2'b01, w(126), 3'd0, '0, 3'd0, 1'b0, 8'h00, 1'b0);
    chk("c7_ready", o_ready, 0);
    idle(1'b1);
    outs("t6_pop", 4'b1111, w(120), w(121), w(122), w(123));
    cyc(2'b11, w(127), 3'd0, w(128), 3'd0, 1'b1, 8'h00, 1'b1);
    outs("t6_flush", 4'b0000, '0, '0, '0, '0);
    chk("t6_ready", o_ready, 1);
    idle(1'b1);
    chk("t6_post1", o_valid, 4'b0000);
    idle(1'b1);
    chk("t6_post2", o_valid, 4'b0000);
    push2(100, 101, 1'b1);
    idle(1'b1);
    outs("t6_restart", 4'b0011, w(100), w(101), '0, '0);

    // Reset while outputs are live clears them at once
    push2(110, 111, 1'b0);
    idle(1'b1);
    chk("r2_pre_valid", o_valid, 4'b0011);
    #2 i_rst = 1'b1;
    #1;
    outs("r2_async", 4'b0000, '0, '0, '0, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
